// File: rtl/arb_pkg.sv
// arb_pkg: shared constants, state encoding and round-robin pick for the arbiter.
package arb_pkg;
   localparam int NREQ = 4;
   typedef enum logic {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;
   // Returns {found, idx}; scans last+1, last+2, ... wrapping, so last itself has lowest priority.
   function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
      logic [2:0] r;
      logic [1:0] idx;
      r = 3'b000;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (req[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction
endpackage

// File: rtl/decoder2_4.sv
// decoder2_4: 2-bit index to raw one-hot vector.
module decoder2_4 (
   input  logic [1:0] i_sel,
   output logic [3:0] o_dec
);
   assign o_dec = 4'b0001 << i_sel;
endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-way round-robin arbiter with a fairness hold limit and registered grant.
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic [1:0]       gnt_id,
   output logic             gnt_valid,
   output logic [CNT_W-1:0] hold_cnt
);
   localparam logic [CNT_W-1:0] HM = CNT_W'(HOLD_MAX);
   state_t           r_state;
   logic [1:0]       r_gnt_id, r_last;
   logic             r_valid;
   logic [CNT_W-1:0] r_hold;
   logic [NREQ-1:0]  w_dec, w_mask;
   logic [2:0]       w_pick;
   logic             w_keep;
   decoder2_4 u_dec (.i_sel(r_gnt_id), .o_dec(w_dec));
   // While granted, the owner is excluded so the pick reflects competing requesters only.
   assign w_mask = req & ~((r_state == ST_GRANT) ? w_dec : '0);
   assign w_pick = rr_pick(w_mask, r_last);
   assign w_keep = (r_state == ST_GRANT) && req[r_gnt_id] && (r_hold < HM || !w_pick[2]);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_gnt_id <= 2'd0;
         r_last   <= 2'd3;
         r_valid  <= 1'b0;
         r_hold   <= '0;
      end else if (w_keep) begin
         r_hold <= (r_hold == HM) ? r_hold : r_hold + CNT_W'(1);
      end else if (w_pick[2]) begin
         r_state  <= ST_GRANT;
         r_gnt_id <= w_pick[1:0];
         r_last   <= w_pick[1:0];
         r_valid  <= 1'b1;
         r_hold   <= CNT_W'(1);
      end else begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_hold  <= '0;
      end
   end
   assign gnt       = r_valid ? w_dec : '0;
   assign gnt_id    = r_gnt_id;
   assign gnt_valid = r_valid;
   assign hold_cnt  = r_hold;
endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed table and sequence checks for rr_arbiter4 (HOLD_MAX=8 and HOLD_MAX=1).
module tb_rr_arbiter4;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt, gnt1;
   logic [1:0] gnt_id, gnt_id1;
   logic       gnt_valid, gnt_valid1;
   logic [7:0] hold_cnt, hold_cnt1;
   int         n_tests = 0;
   int         n_fail = 0;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       vld;
      logic [7:0] hold;
   } vec_t;
   vec_t tbl[9];

   rr_arbiter4 #(.HOLD_MAX(8), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
      .gnt_id(gnt_id), .gnt_valid(gnt_valid), .hold_cnt(hold_cnt)
   );
   rr_arbiter4 #(.HOLD_MAX(1), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt1),
      .gnt_id(gnt_id1), .gnt_valid(gnt_valid1), .hold_cnt(hold_cnt1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step(input logic [3:0] r);
      req = r;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic v, input logic [7:0] h);
      check({tag, ".gnt"}, 32'(gnt), 32'(g));
      check({tag, ".id"}, 32'(gnt_id), 32'(id));
      check({tag, ".vld"}, 32'(gnt_valid), 32'(v));
      check({tag, ".hold"}, 32'(hold_cnt), 32'(h));
   endtask

   initial begin
      tbl[0] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 8'd0};
      tbl[1] = '{4'b0101, 4'b0001, 2'd0, 1'b1, 8'd1};
      tbl[2] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 8'd1};
      tbl[3] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 8'd1};
      tbl[4] = '{4'b0000, 4'b0000, 2'd3, 1'b0, 8'd0};
      tbl[5] = '{4'b1000, 4'b1000, 2'd3, 1'b1, 8'd1};
      tbl[6] = '{4'b1100, 4'b1000, 2'd3, 1'b1, 8'd2};
      tbl[7] = '{4'b0100, 4'b0100, 2'd2, 1'b1, 8'd1};
      tbl[8] = '{4'b0000, 4'b0000, 2'd2, 1'b0, 8'd0};

      #1;
      check_all("reset", 4'b0000, 2'd0, 1'b0, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) check_all("idle", 4'b0000, 2'd0, 1'b0, 8'd0);
      for (int i = 0; i < 5; i++) begin
         step(4'b0000);
         check_all("idle", 4'b0000, 2'd0, 1'b0, 8'd0);
      end

      // All four requesting: each owner holds 8 cycles; the HOLD_MAX=1 copy rotates every cycle.
      for (int k = 0; k < 33; k++) begin
         step(4'b1111);
         check_all("rr1111", 4'b0001 << ((k / 8) % 4), 2'((k / 8) % 4), 1'b1, 8'((k % 8) + 1));
         check("hm1.id", 32'(gnt_id1), 32'(k % 4));
         check("hm1.gnt", 32'(gnt1), 32'(4'b0001 << (k % 4)));
         check("hm1.hold", 32'(hold_cnt1), 32'd1);
      end

      // Lone requester 2: direct handover from 0, then saturating hold with no rotation.
      for (int k = 0; k < 20; k++) begin
         step(4'b0100);
         check_all("solo2", 4'b0100, 2'd2, 1'b1, (k < 7) ? 8'(k + 1) : 8'd8);
      end

      for (int i = 0; i < 9; i++) begin
         step(tbl[i].req);
         check_all($sformatf("tbl%0d", i), tbl[i].gnt, tbl[i].id, tbl[i].vld, tbl[i].hold);
      end

      // Asynchronous reset while requester 1 holds the grant.
      step(4'b0010);
      check_all("pre_rst", 4'b0010, 2'd1, 1'b1, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all("async_rst", 4'b0000, 2'd0, 1'b0, 8'd0);
      req = 4'b1010;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all("post_rst", 4'b0010, 2'd1, 1'b1, 8'd1);
      step(4'b1000);
      check_all("post_rst2", 4'b1000, 2'd3, 1'b1, 8'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- 4-requester round-robin arbiter that shares one downstream resource.
- Produces a registered 2-bit grant index plus a one-hot grant vector; the one-hot vector is produced by the team's 2-to-4 decoder.
- Used wherever four agents contend for a single port: bus slave, shared register bank, UART TX.
- Grant is held while the owner keeps requesting, subject to a hold-time limit that enforces fairness.

Parameters:
- HOLD_MAX, default 8: maximum consecutive grant cycles per owner when other requesters are waiting. Legal range 1..255.
- CNT_W, default 8: width of the hold counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request lines, bit i = requester i, level-sensitive
- gnt  output  4  one-hot grant; all zero when no grant
- gnt_id  output  2  index of current owner; valid only when gnt_valid=1
- gnt_valid  output  1  a grant is active
- hold_cnt  output  CNT_W  cycles the current owner has held the grant (debug)

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, hold_cnt=0, last_owner=2'd3. Priority after reset is therefore 0,1,2,3.
- All outputs are registered.
- A request first seen at edge N produces a grant after edge N, i.e. 1-cycle latency.
- Output relation: gnt = gnt_valid ? decode(gnt_id) : 4'b0000. Never more than one bit set.
- Round-robin pick: search from last_owner+1 upward mod 4; the first set req bit wins. last_owner updates to the winner on every new grant.
- FSM states: IDLE, GRANT.
- IDLE:
  - req==0: stay IDLE.
  - Otherwise: pick winner, go to GRANT, gnt_valid=1, hold_cnt=1.
- GRANT (owner o):
  - req[o]=1 and (hold_cnt<HOLD_MAX or no other req bit set): keep owner. hold_cnt increments and saturates at HOLD_MAX.
  - req[o]=1, hold_cnt==HOLD_MAX, another req set: forced rotation. The next owner is picked from req with bit o masked; hold_cnt=1. No idle gap.
  - req[o]=0, other req set: hand over directly to the round-robin pick from req (bit o is already 0); hold_cnt=1. No idle gap.
  - req[o]=0, req==0: go to IDLE. gnt_valid=0, gnt=0, hold_cnt=0. gnt_id retains its last value.
- Simultaneous events: release and a new request from the same requester in the same cycle are impossible (level protocol). A requester dropping and re-raising req re-enters round-robin order and does not keep priority.
- HOLD_MAX=1: every cycle with a competing request rotates the owner.
- Reset mid-grant: gnt drops to 0 immediately (asynchronous). The first grant after reset follows the reset priority.
- X on req is not handled. The bench must drive known values after reset.

Decomposition:
- Shared package/header arb_pkg holds:
  - NREQ=4
  - state encodings ST_IDLE=1'b0, ST_GRANT=1'b1
  - the round-robin pick function taking (req[3:0], last[1:0]) and returning {found, idx[1:0]}
- Sub-module: decoder2_4, instantiated once to convert gnt_id to the raw one-hot. It is gated by gnt_valid in the parent.
- The FSM, hold counter and pointer stay in rr_arbiter4.

Test Plan:
- Reset then req=4'b0000 for 5 cycles -> gnt=0000, gnt_valid=0, hold_cnt=0 throughout.
- req=4'b1111 held, HOLD_MAX=8 -> gnt_id sequence 0,1,2,3,0. Each owner holds exactly 8 cycles, first grant 1 cycle after req rises, no idle cycles between owners.
- req=4'b0100 only, held 20 cycles -> gnt=0100 for all cycles after the first, hold_cnt saturates at 8, no rotation.
- Owner 1 granted, req drops to 4'b1000 at the same edge -> next cycle gnt=1000, gnt_id=3, hold_cnt=1.
- Owner 2 granted, req goes to 0000 -> next cycle gnt_valid=0, gnt=0000. Then req=4'b0101 -> grant to 0 (search starts at 3, wraps to 0).
- Assert rst_n=0 while gnt=0010 -> gnt=0000 before the next clk edge. After release with req=4'b1010 -> first grant goes to requester 1.
